mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers. Sits in EX beside the combinational ALU.
- Accepts one operation per start pulse and holds busy for a fixed, per-operation latency.
- Exposes HI/LO for mfhi/mflo forwarding.
- Hazard logic stalls D-stage MDU instructions while start or busy is high.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits (even, >= 8).
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd/msub when enabled); >= 1.
- DIV_CYCLES, 10: busy cycles for div/divu; >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request qualifier for op.
- mdu_op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu.
- src_a  input  WIDTH  rs operand; dividend / multiplicand / mthi-mtlo data.
- src_b  input  WIDTH  rt operand; divisor / multiplier.
- busy  output  1  registered; high while a multi-cycle op is in flight.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy=0, hi=0, lo=0, cycle counter=0, FSM=IDLE.
  - The in-flight operation is discarded; no partial result is ever written.
- FSM states:
  - IDLE: start with op 1-4 or 7-10 latches src_a, src_b and op at edge t and goes to RUN; counter loads MULT_CYCLES or DIV_CYCLES.
  - RUN: busy=1; counter decrements each edge. The edge where counter reaches 1 writes the result to hi/lo, clears busy and returns to IDLE.
  - Timing: busy is high for exactly N cycles (edges t+1 .. t+N-1 see busy=1; busy=0 after edge t+N). The result is visible on hi/lo in the same cycle busy falls.
- mthi/mtlo: when start is high in IDLE, write src_a to hi/lo at that edge, with no busy.
- Start in RUN: ignored entirely; operands, op and registers are unaffected. Hazard logic guarantees this never happens; the bench still checks it.
- mdu_op=0, or undefined codes 11-15, with start: no effect.
- Without MDU_MADD_EN, codes 7-10 are also no effect.
- Arithmetic: operands are captured at start, so later input changes are irrelevant.
  - mult: {hi,lo} = signed(a)*signed(b), 2*WIDTH bits.
  - multu: the same, unsigned.
  - div: lo = quotient, hi = remainder. Truncation toward zero; remainder takes the sign of the dividend.
  - divu: unsigned equivalent.
- Division boundary cases:
  - Divide by zero (div or divu): after full latency, hi = a, lo = all ones. busy timing is unchanged.
  - Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0.
- hi and lo are pure register outputs; no combinational path from inputs.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: codes 7-10 are valid with MULT_CYCLES latency.
  - madd: {hi,lo} += signed product.
  - maddu: {hi,lo} += unsigned product.
  - msub: {hi,lo} -= signed product.
  - msubu: {hi,lo} -= unsigned product.
  - Arithmetic is modulo 2^(2*WIDTH).
  - The {hi,lo} accumulation base is the value at the completion edge.
- Undefined: codes 7-10 are treated as none; no accumulator adder is synthesised.

Test Plan:
- Reset, then start mult with a=0xFFFFFFFE, b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. During busy, hi/lo keep their prior value 0.
- Start divu with a=100, b=7 -> busy for 10 cycles; then lo=14, hi=2. Start div with a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div with a=0x12345678, b=0 -> after 10 cycles hi=0x12345678, lo=0xFFFFFFFF. div with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi with 0xA5A5A5A5, then mtlo with 0x5A5A5A5A on back-to-back cycles -> hi and lo each update at their own edge; busy stays 0. Start mult during busy with different operands -> ignored; only the first result appears.
- Start multu, assert reset 2 cycles in -> busy=0, hi=lo=0 immediately. After reset release, hi/lo stay 0 and no late write-back occurs.
- With MDU_MADD_EN: mtlo 0xFFFFFFFF, mthi 0, then maddu a=1, b=1 -> hi=1, lo=0. Then msub a=1, b=1 -> hi=0, lo=0xFFFFFFFF.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulation into {hi,lo}.
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             busy_q;

  // Decode of the incoming request.
  logic op_mult, op_div;
  always_comb begin
    op_div  = (mdu_op == OpDiv) || (mdu_op == OpDivu);
    op_mult = (mdu_op == OpMult) || (mdu_op == OpMultu);
`ifdef MDU_MADD_EN
    op_mult = op_mult || (mdu_op == OpMadd) || (mdu_op == OpMaddu) ||
              (mdu_op == OpMsub) || (mdu_op == OpMsubu);
`endif
  end

  // Products taken modulo 2^(2*WIDTH); sign extension gives the signed result.
  logic [2*WIDTH-1:0] prod_s, prod_u;
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Signed division via magnitudes; most-negative / -1 wraps back to most-negative.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b, divisor, quo_u, rem_u, quo, rem;
  always_comb begin
    a_neg   = (op_q == OpDiv) && a_q[WIDTH-1];
    b_neg   = (op_q == OpDiv) && b_q[WIDTH-1];
    b_zero  = (b_q == '0);
    abs_a   = a_neg ? -a_q : a_q;
    abs_b   = b_neg ? -b_q : b_q;
    divisor = b_zero ? WIDTH'(1) : abs_b;
    quo_u   = abs_a / divisor;
    rem_u   = abs_a % divisor;
    quo     = (a_neg ^ b_neg) ? -quo_u : quo_u;
    rem     = a_neg ? -rem_u : rem_u;
  end

  logic [WIDTH-1:0] res_hi, res_lo;
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OpMult:  {res_hi, res_lo} = prod_s;
      OpMultu: {res_hi, res_lo} = prod_u;
      OpDiv, OpDivu: begin
        if (b_zero) begin
          res_hi = a_q;
          res_lo = '1;
        end else begin
          res_hi = rem;
          res_lo = quo;
        end
      end
`ifdef MDU_MADD_EN
      OpMadd:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      OpMaddu: {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
      OpMsub:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
      OpMsubu: {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (op_mult || op_div) begin
              a_q     <= src_a;
              b_q     <= src_b;
              op_q    <= mdu_op;
              cnt_q   <= op_div ? DivCnt : MultCnt;
              busy_q  <= 1'b1;
              state_q <= StRun;
            end else if (mdu_op == OpMthi) begin
              hi_q <= src_a;
            end else if (mdu_op == OpMtlo) begin
              lo_q <= src_a;
            end
          end
        end
        StRun: begin
          // Requests arriving here are dropped; hazard logic should prevent them.
          if (cnt_q == CntOne) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit (WIDTH=32, 5/10 cycle latencies).
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;

  int          vectors = 0;
  int          miscompares = 0;
  int          n_busy;
  logic        changed;
  logic [31:0] prev_hi, prev_lo;

  mdu_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdu_op(mdu_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdu_op = op;
    src_a  = a;
    src_b  = b;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 4'd0;
    src_a  = 32'hDEADBEEF;
    src_b  = 32'h0BADF00D;
  endtask

  task automatic wait_idle();
    while (busy === 1'b1 && n_busy < 200) begin
      n_busy++;
      if (hi !== prev_hi || lo !== prev_lo) changed = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cyc, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    prev_hi = hi;
    prev_lo = lo;
    n_busy  = 0;
    changed = 1'b0;
    start_op(op, a, b);
    wait_idle();
    check({tag, "_cycles"}, 32'(n_busy), 32'(cyc));
    check({tag, "_hold"}, {31'b0, changed}, 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic noop_check(input string tag, input logic [3:0] op);
    prev_hi = hi;
    prev_lo = lo;
    start_op(op, 32'h12345678, 32'd9);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_hi"}, hi, prev_hi);
    check({tag, "_lo"}, lo, prev_lo);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = 4'd0;
    src_a  = '0;
    src_b  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("mult_nn", 4'd1, 32'hFFFFFFFD, 32'hFFFFFFFB, 5, 32'h0, 32'h0000000F);
    run_op("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m1", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h0, 32'h1);
    run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("div_negA", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negB", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
    run_op("div_zero", 4'd3, 32'h12345678, 32'd0, 10, 32'h12345678, 32'hFFFFFFFF);
    run_op("divu_zero", 4'd4, 32'hFFFFFFFF, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    run_op("divu_big", 4'd4, 32'h80000000, 32'hFFFFFFFF, 10, 32'h80000000, 32'h0);

    // mthi then mtlo on back-to-back edges
    prev_lo = lo;
    start  = 1'b1;
    mdu_op = 4'd5;
    src_a  = 32'hA5A5A5A5;
    @(negedge clk);
    check("mthi_hi", hi, 32'hA5A5A5A5);
    check("mthi_lo", lo, prev_lo);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    mdu_op = 4'd6;
    src_a  = 32'h5A5A5A5A;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 4'd0;
    check("mtlo_lo", lo, 32'h5A5A5A5A);
    check("mtlo_hi", hi, 32'hA5A5A5A5);
    check("mtlo_busy", {31'b0, busy}, 32'd0);

    noop_check("op0", 4'd0);
    noop_check("op11", 4'd11);
    noop_check("op15", 4'd15);
`ifndef MDU_MADD_EN
    noop_check("op7_off", 4'd7);
    noop_check("op10_off", 4'd10);
`endif

    // A second start while running must be ignored.
    prev_hi = hi;
    prev_lo = lo;
    changed = 1'b0;
    start_op(4'd1, 32'd2, 32'd3);
    check("run_busy", {31'b0, busy}, 32'd1);
    start  = 1'b1;
    mdu_op = 4'd2;
    src_a  = 32'd7;
    src_b  = 32'd9;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 4'd0;
    n_busy = 1;
    wait_idle();
    check("ign_cycles", 32'(n_busy), 32'd5);
    check("ign_hold", {31'b0, changed}, 32'd0);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd6);

    // Reset two cycles into a multu discards it.
    start_op(4'd5, 32'hCAFEF00D, 32'd0);
    check("pre_rst_hi", hi, 32'hCAFEF00D);
    start_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    changed = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) changed = 1'b1;
    end
    check("post_rst_quiet", {31'b0, changed}, 32'd0);

`ifdef MDU_MADD_EN
    start_op(4'd6, 32'hFFFFFFFF, 32'd0);
    start_op(4'd5, 32'd0, 32'd0);
    check("acc_init_lo", lo, 32'hFFFFFFFF);
    run_op("maddu", 4'd8, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    run_op("msub", 4'd9, 32'd1, 32'd1, 5, 32'd0, 32'hFFFFFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
